// File: rtl/alu_result_accumulator.sv
// rtl/alu_result_accumulator.sv - sums a programmable group of ALU results and emits the total
module alu_result_accumulator #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned CountWidth = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DataWidth-1:0]  result_i,
  input  logic                  result_valid_i,
  output logic                  result_ready_o,
  input  logic [CountWidth-1:0] acc_len_i,
  output logic [DataWidth-1:0]  acc_o,
  output logic                  acc_overflow_o,
  output logic                  acc_valid_o,
  input  logic                  acc_ready_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DataWidth-1:0]  acc_q;
  logic                  ovf_q;
  logic [CountWidth-1:0] count_q;
  logic [CountWidth-1:0] len_q;

  logic                  beat;
  logic                  out_hs;
  logic [CountWidth-1:0] len_eff;
  logic [CountWidth-1:0] count_inc;
  logic [DataWidth:0]    sum;

  assign beat      = result_valid_i && result_ready_o;
  assign out_hs    = acc_valid_o && acc_ready_i;
  // A zero length would never terminate the group, so it is promoted to one.
  assign len_eff   = (acc_len_i == '0) ? CountWidth'(1) : acc_len_i;
  assign count_inc = count_q + CountWidth'(1);
  assign sum       = {1'b0, acc_q} + {1'b0, result_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (beat) begin
          state_d = (len_eff == CountWidth'(1)) ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (beat && (count_inc == len_q)) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat) begin
            len_q   <= len_eff;
            acc_q   <= result_i;
            ovf_q   <= 1'b0;
            count_q <= CountWidth'(1);
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_q   <= sum[DataWidth-1:0];
            ovf_q   <= ovf_q | sum[DataWidth];
            count_q <= count_inc;
          end
        end
        OUTPUT: begin
          if (out_hs) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Ready is held low during reset so no beat is implied before the first clock.
  always_comb begin
    result_ready_o = rst_ni && (state_q != OUTPUT);
    acc_valid_o    = (state_q == OUTPUT);
    busy_o         = (state_q == ACCUM);
    acc_o          = acc_q;
    acc_overflow_o = ovf_q;
  end

endmodule

// File: doc/alu_result_accumulator.md
Name: alu_result_accumulator

Overview:
Downstream consumer of the ALU result stream (result/valid/ready). Sums a programmable number of consecutive ALU results into one DataWidth total, with a sticky unsigned-overflow flag. Presents each group total on a valid/ready output port toward the next stage (CSR readback or streamer).

Parameters:
DataWidth, 64, width of incoming results and of the accumulated sum
CountWidth, 8, width of the group-length input and beat counter

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous, active-low reset
result_i  input  DataWidth  ALU result beat
result_valid_i  input  1  result beat valid
result_ready_o  output  1  accumulator can take a beat
acc_len_i  input  CountWidth  results per group; sampled at group start; 0 treated as 1
acc_o  output  DataWidth  group sum, modulo 2^DataWidth
acc_overflow_o  output  1  carry out occurred during the group; qualified by acc_valid_o
acc_valid_o  output  1  group sum valid
acc_ready_i  input  1  downstream accepts group sum
busy_o  output  1  group in progress (state ACCUM)

Behaviour:
- Reset (rst_ni=0, async): state IDLE; acc, count, overflow, latched length = 0. Outputs: acc_o=0, acc_overflow_o=0, acc_valid_o=0, busy_o=0, result_ready_o=0 while in reset, then 1 in IDLE.
- Beat handshake: result_valid_i && result_ready_o. result_ready_o = 1 in IDLE and ACCUM, 0 in OUTPUT. Combinational only on state; never depends on result_valid_i.
- Output handshake: acc_valid_o && acc_ready_i. acc_valid_o = 1 only in OUTPUT. acc_o and acc_overflow_o are held stable while acc_valid_o=1.
- FSM:
  - IDLE: on beat: len_q <= max(acc_len_i,1); acc <= result_i; overflow <= 0; count <= 1. If len_q == 1, go to OUTPUT; otherwise go to ACCUM. With no beat, stay in IDLE.
  - ACCUM: on beat: {carry,acc} <= acc + result_i (DataWidth+1 bits); overflow <= overflow | carry; count <= count+1. If count+1 == len_q, go to OUTPUT. acc_len_i is ignored in this state.
  - OUTPUT: on output handshake: clear acc, count and overflow, then go to IDLE. Otherwise hold.
- Latency: the final beat accepted in cycle t gives acc_valid_o=1 in cycle t+1. The earliest next beat is the cycle after the output handshake, so there is one bubble cycle per group plus any downstream stall.
- A beat and an output handshake are never simultaneous, because ready=0 in OUTPUT.
- busy_o = 1 exactly in ACCUM.
- Counter does not wrap: max group length is 2^CountWidth-1. acc_len_i = 0 behaves identically to 1.
- Sum arithmetic is unsigned modular. Subtraction results from the ALU are summed as raw bit patterns.
- Reset asserted mid-group or in OUTPUT discards the partial sum immediately; no output is produced.
- Inputs with valid low are don't-care. result_i is sampled only on a handshake.

Test Plan:
- Reset values: hold rst_ni=0, then release -> acc_valid_o=0, busy_o=0, acc_o=0, result_ready_o=1 in the first cycle after release.
- Group of 3: acc_len_i=3; beats 5, 7, 10 back-to-back with acc_ready_i=1 -> busy_o high after beat 1; acc_o=22, acc_overflow_o=0, acc_valid_o high exactly 1 cycle after beat 3; result_ready_o=0 in that cycle.
- Length 0 and 1: acc_len_i=0, beat 0xAB -> acc_o=0xAB valid next cycle, busy_o never high; repeat with acc_len_i=1 -> identical.
- Overflow with DataWidth=64: acc_len_i=2; beats 0xFFFF_FFFF_FFFF_FFFF and 2 -> acc_o=1, acc_overflow_o=1. Next group 1+1 -> acc_o=2, acc_overflow_o=0 (flag cleared).
- Backpressure and mid-group length change: acc_len_i=2, beats 3 and 4, acc_ready_i=0 for 5 cycles -> acc_o=7 held, result_ready_o=0 throughout. Changing acc_len_i to 9 during ACCUM has no effect. After acc_ready_i=1, IDLE is entered and a beat is accepted the next cycle.
- Reset mid-group: acc_len_i=4, 2 beats accepted, then rst_ni pulsed low -> no acc_valid_o. A new group with acc_len_i=2 and beats 1, 1 -> acc_o=2.
